// File: rtl/cla_pipe_adder_pkg.sv
// rtl/cla_pipe_adder_pkg.sv - shared sizing helpers, stage record and lookahead carry function
package cla_pkg;

    localparam int LA_MAX = 64;

    function automatic int stage_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic int groups_per_stage(input int width, input int stages, input int group);
        return width / (stages * group);
    endfunction

    typedef struct packed {
        logic valid;
        logic sub;
        logic carry;
    } stage_ctl_t;

    // Flat sum-of-products carry into position n: no term depends on an earlier carry.
    function automatic logic la_carry(input logic [LA_MAX-1:0] g, input logic [LA_MAX-1:0] p,
                                      input logic c0, input int n);
        logic res;
        logic pr;
        res = 1'b0;
        pr  = 1'b1;
        for (int i = LA_MAX - 1; i >= 0; i--) begin
            if (i < n) begin
                res = res | (pr & g[i]);
                pr  = pr & p[i];
            end
        end
        return res | (pr & c0);
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// rtl/cla_pipe_adder_if.sv - operand/result handshake bundle for cla_pipe_adder
interface cla_pipe_adder_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             crout;
    logic             ovf;

    modport master (
        output in_valid, op1, op2, cin, sub, out_ready,
        input  in_ready, out_valid, sum, crout, ovf
    );

    modport slave (
        input  in_valid, op1, op2, cin, sub, out_ready,
        output in_ready, out_valid, sum, crout, ovf
    );
endinterface

// File: rtl/cla_pipe_adder_group.sv
// rtl/cla_pipe_adder_group.sv - GROUP-bit lookahead cell producing sum and group P/G
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] sum,
    output logic             gp,
    output logic             gg
);
    logic [GROUP-1:0]  p;
    logic [GROUP-1:0]  g;
    logic [LA_MAX-1:0] p_x;
    logic [LA_MAX-1:0] g_x;

    assign p   = a ^ b;
    assign g   = a & b;
    assign p_x = LA_MAX'(p);
    assign g_x = LA_MAX'(g);

    // Group P/G kept apart from the sum logic so they never depend on c_in.
    assign gp = &p;
    assign gg = la_carry(g_x, p_x, 1'b0, GROUP);

    always_comb begin
        sum = '0;
        for (int i = 0; i < GROUP; i++) begin
            sum[i] = p[i] ^ la_carry(g_x, p_x, c_in, i);
        end
    end
endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic             clock,
    input  logic             reset,
    cla_pipe_adder_if.slave  bus
);
    localparam int SW = stage_width(WIDTH, STAGES);
    localparam int NG = groups_per_stage(WIDTH, STAGES, GROUP);

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } stage_t;

    stage_t entry;
    stage_t cur [STAGES];
    stage_t nxt [STAGES];
    stage_t r   [STAGES];

    logic [STAGES-1:0][NG-1:0] gp;
    logic [STAGES-1:0][NG-1:0] gg;
    logic [STAGES-1:0][NG:0]   gc;
    logic [STAGES-1:0][SW-1:0] ssum;
    logic                      stall;
    logic                      ovf_nxt;
    logic                      ovf_r;

    assign stall        = r[STAGES-1].ctl.valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // B is inverted once at entry; the effective carry-in folds in the borrow sense.
    always_comb begin
        entry           = '0;
        entry.ctl.valid = bus.in_valid;
        entry.ctl.sub   = bus.sub;
        entry.ctl.carry = bus.cin ^ bus.sub;
        entry.a         = bus.op1;
        entry.b         = bus.sub ? ~bus.op2 : bus.op2;
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) cur[k] = entry;
            else        cur[k] = r[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        for (genvar j = 0; j < NG; j++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .a    (cur[k].a[k*SW + j*GROUP +: GROUP]),
                .b    (cur[k].b[k*SW + j*GROUP +: GROUP]),
                .c_in (gc[k][j]),
                .sum  (ssum[k][j*GROUP +: GROUP]),
                .gp   (gp[k][j]),
                .gg   (gg[k][j])
            );
        end
    end

    // Second-level lookahead: every group carry straight from group P/G and the stage carry-in.
    always_comb begin
        gc = '0;
        for (int k = 0; k < STAGES; k++) begin
            for (int jj = 0; jj <= NG; jj++) begin
                gc[k][jj] = la_carry(LA_MAX'(gg[k]), LA_MAX'(gp[k]), cur[k].ctl.carry, jj);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt[k]               = cur[k];
            nxt[k].s[k*SW +: SW] = ssum[k];
            nxt[k].ctl.carry     = gc[k][NG];
        end
    end

    assign ovf_nxt = (cur[STAGES-1].a[WIDTH-1] == cur[STAGES-1].b[WIDTH-1]) &&
                     (nxt[STAGES-1].s[WIDTH-1] != cur[STAGES-1].a[WIDTH-1]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) r[k] <= '0;
            ovf_r <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) r[k] <= nxt[k];
            ovf_r <= ovf_nxt;
        end
    end

    assign bus.out_valid = r[STAGES-1].ctl.valid;
    assign bus.sum       = r[STAGES-1].s;
    assign bus.crout     = r[STAGES-1].ctl.carry;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - scoreboard bench for cla_pipe_adder in three pipeline configurations
module tb_cla_pipe_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        crout;
        logic        ovf;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] op1 = '0;
    logic [63:0] op2 = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        rdy = 1'b1;
    logic        done = 1'b0;
    int          tests = 0;
    int          fails = 0;

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic, overflow judged by whether the exact signed result fits.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic c, input logic s);
        exp_t               e;
        logic [64:0]        full;
        logic signed [65:0] sa, sb, sc, ext;
        sa = $signed({{2{a[63]}}, a});
        sb = $signed({{2{b[63]}}, b});
        sc = $signed({65'd0, c});
        if (s) begin
            full    = {1'b0, a} - {1'b0, b} - {64'd0, c};
            e.crout = ~full[64];
            ext     = sa - sb - sc;
        end else begin
            full    = {1'b0, a} + {1'b0, b} + {64'd0, c};
            e.crout = full[64];
            ext     = sa + sb + sc;
        end
        e.sum = full[63:0];
        e.ovf = (ext[65:63] != 3'b000) && (ext[65:63] != 3'b111);
        return e;
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int ST = (i == 0) ? 2 : (i == 1) ? 4 : 1;
        localparam int GR = (i == 1) ? 8 : 4;

        cla_pipe_adder_if #(.WIDTH(64)) bus ();

        assign bus.in_valid  = in_valid;
        assign bus.op1       = op1;
        assign bus.op2       = op2;
        assign bus.cin       = cin;
        assign bus.sub       = sub;
        assign bus.out_ready = (i == 0) ? rdy : 1'b1;

        cla_pipe_adder #(.WIDTH(64), .STAGES(ST), .GROUP(GR)) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );

        exp_t q[$];
        exp_t held;
        exp_t got;
        logic held_v = 1'b0;

        always @(negedge clock) begin
            if (!reset) begin
                q.delete();
                held_v = 1'b0;
            end else begin
                got = {bus.sum, bus.crout, bus.ovf};
                if (held_v)
                    check($sformatf("hold%0d", i), {bus.out_valid, got}, {1'b1, held});
                if (bus.out_valid && !bus.out_ready) begin
                    check($sformatf("stall_ready%0d", i), bus.in_ready, 0);
                    held   = got;
                    held_v = 1'b1;
                end else begin
                    held_v = 1'b0;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected%0d: got result %0h, expected no output", i, got);
                    end else begin
                        check($sformatf("result%0d", i), got, q.pop_front());
                    end
                end
                if (bus.in_valid && bus.in_ready)
                    q.push_back(model(bus.op1, bus.op2, bus.cin, bus.sub));
            end
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
        logic acc;
        op1 = a; op2 = b; cin = c; sub = s;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clock);
            acc = g[0].bus.in_ready;
            @(posedge clock);
            #1;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept: in_ready 0 for 50 cycles, expected 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int outstanding;
        rdy = 1'b1;
        outstanding = 1;
        for (int t = 0; t < 100 && outstanding != 0; t++) begin
            @(negedge clock);
            outstanding = g[0].q.size() + g[1].q.size() + g[2].q.size();
        end
        check("drain", outstanding, 0);
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string nm, input logic ov, input logic [63:0] s,
                            input logic c, input logic o, input logic ir);
        check(nm, {ov, s, c, o, ir}, {1'b0, 64'd0, 1'b0, 1'b0, 1'b1});
    endtask

    function automatic logic [63:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        #12;
        chk_idle("reset0", g[0].bus.out_valid, g[0].bus.sum, g[0].bus.crout, g[0].bus.ovf, g[0].bus.in_ready);
        chk_idle("reset1", g[1].bus.out_valid, g[1].bus.sum, g[1].bus.crout, g[1].bus.ovf, g[1].bus.in_ready);
        chk_idle("reset2", g[2].bus.out_valid, g[2].bus.sum, g[2].bus.crout, g[2].bus.ovf, g[2].bus.in_ready);
        #6 reset = 1'b1;
        @(posedge clock);
        #1;

        // Result appears STAGES cycles after the cycle the operand was presented.
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hEEEE_DDDD_CCCC_FFFF, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("latency0_%0d", j), g[0].bus.out_valid, (j == 1));
            check($sformatf("latency1_%0d", j), g[1].bus.out_valid, (j == 3));
            check($sformatf("latency2_%0d", j), g[2].bus.out_valid, (j == 0));
            @(posedge clock);
            #1;
        end

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hEEEE_DDDD_CCCC_FFFF, 1'b0, 1'b0);
        issue(64'd5, 64'd7, 1'b0, 1'b1);
        issue(64'd7, 64'd5, 1'b1, 1'b1);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        issue(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        issue(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
        issue(64'd0, 64'd0, 1'b0, 1'b1);
        drain();

        fork
            begin
                for (int n = 0; n < 6; n++) issue(rand_op(), rand_op(), 1'($urandom), 1'($urandom));
            end
            begin
                repeat (3) @(posedge clock);
                #1 rdy = 1'b0;
                repeat (3) @(posedge clock);
                #1 rdy = 1'b1;
            end
        join
        drain();

        issue(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        issue(64'h1234_5678_9ABC_DEF0, 64'd3, 1'b1, 1'b1);
        #3 reset = 1'b0;
        #1;
        chk_idle("midreset0", g[0].bus.out_valid, g[0].bus.sum, g[0].bus.crout, g[0].bus.ovf, g[0].bus.in_ready);
        chk_idle("midreset1", g[1].bus.out_valid, g[1].bus.sum, g[1].bus.crout, g[1].bus.ovf, g[1].bus.in_ready);
        chk_idle("midreset2", g[2].bus.out_valid, g[2].bus.sum, g[2].bus.crout, g[2].bus.ovf, g[2].bus.in_ready);
        @(negedge clock);
        #2 reset = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clock);
            check($sformatf("stale%0d", j), {g[0].bus.out_valid, g[1].bus.out_valid, g[2].bus.out_valid}, 0);
        end
        @(posedge clock);
        #1;

        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clock);
                        #1;
                    end
                    issue(rand_op(), rand_op(), 1'($urandom), 1'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock);
                    #1 rdy = ($urandom_range(0, 3) != 0);
                end
                rdy = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
